// File: rtl/apb_master_bridge.sv
// Valid/ready request/response to AMBA3/4 APB master bridge.
// Decodes one of P_NUM slave windows and runs SETUP/ACCESS with wait states and an optional timeout.
module apb_master_bridge #(
   parameter int unsigned P_NUM        = 3,
   parameter logic [31:0] P_ADDR_START = 32'h0000_0000,
   parameter int unsigned P_SIZE       = 1024,
   parameter int unsigned P_TIMEOUT    = 255
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [31:0]           req_addr,
   input  logic                  req_write,
   input  logic [31:0]           req_wdata,
   input  logic [3:0]            req_strb,
   input  logic [2:0]            req_prot,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic [P_NUM-1:0]      PSEL,
   output logic [31:0]           PADDR,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [31:0]           PWDATA,
   output logic [3:0]            PSTRB,
   output logic [2:0]            PPROT,
   input  logic [32*P_NUM-1:0]   PRDATA,
   input  logic [P_NUM-1:0]      PREADY,
   input  logic [P_NUM-1:0]      PSLVERR
);

   localparam int IW = (P_NUM > 1) ? $clog2(P_NUM) : 1;
   localparam int SW = $clog2(P_SIZE);
   localparam int CW = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t        state, state_nx;
   logic [IW-1:0] idx;
   logic [CW-1:0] cnt;
   logic [CW:0]   cnt_inc;
   logic [31:0]   off, dec_idx;
   logic          hit, accept, tmo;
   logic          s_ready, s_err;
   logic [31:0]   s_rdata;

   assign off       = req_addr - P_ADDR_START;
   assign dec_idx   = off >> SW;
   assign hit       = (req_addr >= P_ADDR_START) && (dec_idx < P_NUM);
   assign req_ready = (state == IDLE) && !PRESET;
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == RESP);
   assign PENABLE   = (state == ACCESS);
   assign cnt_inc   = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
   // Abort on the P_TIMEOUT-th ACCESS cycle that still sees PREADY low.
   assign tmo       = (P_TIMEOUT != 0) && (cnt_inc == (CW+1)'(P_TIMEOUT));

   // Only the selected slave's return signals are observed.
   always_comb begin
      s_ready = 1'b0;
      s_err   = 1'b0;
      s_rdata = '0;
      PSEL    = '0;
      for (int i = 0; i < P_NUM; i++) begin
         if (idx == IW'(i)) begin
            s_ready = PREADY[i];
            s_err   = PSLVERR[i];
            s_rdata = PRDATA[32*i +: 32];
            PSEL[i] = (state == SETUP) || (state == ACCESS);
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = hit ? SETUP : RESP;
         SETUP:   state_nx = ACCESS;
         ACCESS:  if (s_ready || tmo) state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state     <= IDLE;
         idx       <= '0;
         cnt       <= '0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         PSTRB     <= '0;
         PPROT     <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (accept) begin
               idx       <= hit ? dec_idx[IW-1:0] : '0;
               cnt       <= '0;
               PADDR     <= req_addr;
               PWRITE    <= req_write;
               PWDATA    <= req_wdata;
               PSTRB     <= req_write ? req_strb : 4'h0;
               PPROT     <= req_prot;
               rsp_rdata <= '0;
               rsp_err   <= !hit;
            end
            ACCESS: begin
               if (s_ready) begin
                  rsp_err   <= s_err;
                  rsp_rdata <= (!PWRITE && !s_err) ? s_rdata : '0;
               end else if (tmo) begin
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
                  cnt <= cnt_inc[CW-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: behavioural APB slaves with wait/stall/error knobs
// and a response scoreboard.
module tb_apb_master_bridge;

   localparam int NS = 3;

   logic             PCLK = 1'b0;
   logic             PRESET;
   logic             req_valid, req_ready, req_write;
   logic [31:0]      req_addr, req_wdata;
   logic [3:0]       req_strb;
   logic [2:0]       req_prot;
   logic             rsp_valid, rsp_ready, rsp_err;
   logic [31:0]      rsp_rdata;
   logic [NS-1:0]    PSEL, PREADY, PSLVERR;
   logic [31:0]      PADDR, PWDATA;
   logic             PENABLE, PWRITE;
   logic [3:0]       PSTRB;
   logic [2:0]       PPROT;
   logic [32*NS-1:0] PRDATA;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   // slave models
   logic [31:0]   mem [0:NS-1][0:255];
   int            delay [NS];
   int            wcnt  [NS];
   logic [NS-1:0] stuck, force_err;

   always #5 PCLK = ~PCLK;

   apb_master_bridge #(
      .P_NUM(NS), .P_ADDR_START(32'h0000_0000), .P_SIZE(1024), .P_TIMEOUT(4)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
      .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .PSEL(PSEL), .PADDR(PADDR),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   for (genvar s = 0; s < NS; s++) begin : g_slv
      assign PREADY[s]          = PSEL[s] & PENABLE & ~stuck[s] & (wcnt[s] >= delay[s]);
      assign PSLVERR[s]         = PSEL[s] & PENABLE & force_err[s];
      assign PRDATA[32*s +: 32] = mem[s][PADDR[9:2]];
   end

   always @(posedge PCLK) begin
      for (int s = 0; s < NS; s++) begin
         if (PSEL[s] && PENABLE && !PREADY[s]) wcnt[s] <= wcnt[s] + 1;
         else wcnt[s] <= 0;
         if (PSEL[s] && PENABLE && PREADY[s] && PWRITE && !PSLVERR[s])
            for (int b = 0; b < 4; b++)
               if (PSTRB[b]) mem[s][PADDR[9:2]][8*b +: 8] <= PWDATA[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request; hold = cycles to keep rsp_ready low once rsp_valid is seen.
   task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                       input logic [NS-1:0] exp_psel, input int hold);
      int            lat, n;
      logic [NS-1:0] psel_or;
      logic          bad, hbad;
      logic [31:0]   rd0;
      exp_t          e;
      @(negedge PCLK);
      req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd;
      req_strb = st; req_prot = pr; rsp_ready = (hold == 0);
      sb.push_back('{exp_rd, exp_err});
      n = 0;
      while (!req_ready && n < 20) begin @(negedge PCLK); n++; end
      chk({tag, " accept"}, 32'(req_ready), 32'd1);
      @(negedge PCLK);
      req_valid = 1'b0;
      lat = 1; psel_or = '0; bad = 1'b0;
      while (!rsp_valid && lat < 40) begin
         psel_or |= PSEL;
         if (PSEL != '0 && (PADDR !== addr || PWRITE !== wr || PPROT !== pr ||
             PSTRB !== (wr ? st : 4'h0) || (wr && PWDATA !== wd))) bad = 1'b1;
         if (!$onehot0(PSEL) || (PENABLE && PSEL == '0)) bad = 1'b1;
         @(negedge PCLK); lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " psel"}, 32'(psel_or), 32'(exp_psel));
      chk({tag, " bus stable"}, 32'(bad), 32'd0);
      rd0 = rsp_rdata; hbad = 1'b0;
      for (int i = 0; i < hold; i++) begin
         if (!rsp_valid || req_ready || rsp_rdata !== rd0 || PSEL != '0) hbad = 1'b1;
         @(negedge PCLK);
      end
      if (hold > 0) chk({tag, " backpressure hold"}, 32'(hbad), 32'd0);
      rsp_ready = 1'b1;
      e = sb.pop_front();
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " rdata"}, rsp_rdata, e.rdata);
      chk({tag, " err"}, 32'(rsp_err), 32'(e.err));
      chk({tag, " idle bus in resp"}, 32'({PSEL, PENABLE}), 32'd0);
      @(negedge PCLK);
      chk({tag, " rsp released"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      PRESET = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
      req_wdata = '0; req_strb = '0; req_prot = '0; rsp_ready = 1'b0;
      stuck = '0; force_err = '0;
      for (int s = 0; s < NS; s++) delay[s] = 0;
      repeat (3) @(negedge PCLK);
      chk("reset psel/penable", 32'({PSEL, PENABLE}), 32'd0);
      chk("reset rsp", 32'({rsp_valid, rsp_err}), 32'd0);
      chk("reset rdata", rsp_rdata, 32'd0);
      chk("reset paddr", PADDR, 32'd0);
      chk("reset pwdata", PWDATA, 32'd0);
      chk("reset ctl", 32'({PWRITE, PSTRB, PPROT}), 32'd0);
      chk("reset req_ready", 32'(req_ready), 32'd0);
      PRESET = 1'b0;
      @(negedge PCLK);
      chk("idle req_ready", 32'(req_ready), 32'd1);

      xfer("wr s1",      32'h0000_0404, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010, 32'h0, 1'b0, 3, 3'b010, 0);
      xfer("rd s1",      32'h0000_0404, 1'b0, 32'h0, 4'hF, 3'b000, 32'hDEAD_BEEF, 1'b0, 3, 3'b010, 0);
      xfer("wr s1 strb", 32'h0000_0404, 1'b1, 32'h1234_5678, 4'b0011, 3'b001, 32'h0, 1'b0, 3, 3'b010, 0);
      xfer("rd s1 strb", 32'h0000_0404, 1'b0, 32'h0, 4'h0, 3'b000, 32'hDEAD_5678, 1'b0, 3, 3'b010, 0);
      xfer("wr s0",      32'h0000_0010, 1'b1, 32'hA5A5_0001, 4'hF, 3'b111, 32'h0, 1'b0, 3, 3'b001, 0);
      xfer("rd s0",      32'h0000_0010, 1'b0, 32'h0, 4'h0, 3'b000, 32'hA5A5_0001, 1'b0, 3, 3'b001, 0);

      delay[2] = 3;
      xfer("wr s2 wait", 32'h0000_0810, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b000, 32'h0, 1'b0, 6, 3'b100, 0);
      xfer("rd s2 wait", 32'h0000_0810, 1'b0, 32'h0, 4'h0, 3'b000, 32'hCAFE_F00D, 1'b0, 6, 3'b100, 0);
      delay[2] = 0;

      xfer("rd decode miss", 32'h0000_0C00, 1'b0, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 1, 3'b000, 0);
      xfer("wr decode miss", 32'hFFFF_FFF0, 1'b1, 32'h1111_2222, 4'hF, 3'b000, 32'h0, 1'b1, 1, 3'b000, 0);

      stuck[2] = 1'b1;
      xfer("rd timeout", 32'h0000_0820, 1'b0, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 6, 3'b100, 0);
      stuck[2] = 1'b0;

      force_err[1] = 1'b1;
      xfer("rd pslverr", 32'h0000_0404, 1'b0, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 3, 3'b010, 0);
      force_err[1] = 1'b0;

      xfer("rd backpressure", 32'h0000_0404, 1'b0, 32'h0, 4'h0, 3'b000, 32'hDEAD_5678, 1'b0, 3, 3'b010, 5);

      // reset while a stalled transfer sits in ACCESS
      stuck[2] = 1'b1;
      @(negedge PCLK);
      req_valid = 1'b1; req_addr = 32'h0000_0820; req_write = 1'b0;
      @(negedge PCLK);
      req_valid = 1'b0;
      @(negedge PCLK);
      chk("mid reset in access", 32'({PSEL, PENABLE}), 32'b1001);
      PRESET = 1'b1;
      @(negedge PCLK);
      chk("mid reset psel/penable", 32'({PSEL, PENABLE}), 32'd0);
      chk("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid reset req_ready", 32'(req_ready), 32'd0);
      PRESET = 1'b0; stuck[2] = 1'b0;
      xfer("rd after reset", 32'h0000_0010, 1'b0, 32'h0, 4'h0, 3'b000, 32'hA5A5_0001, 1'b0, 3, 3'b001, 0);

      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream neighbour of the APB memory slaves: converts a simple valid/ready request/response interface into AMBA3/4 APB transfers.
- Decodes the address to one of P_NUM slave selects and runs the SETUP/ACCESS protocol with PREADY wait states.
- Returns read data and error status (PSLVERR, decode error, timeout) on a response channel.
- Synthesizable replacement for the task-based APB BFM on the same bus.

Parameters:
- P_NUM, 3, number of APB slaves (1..16).
- P_ADDR_START, 32'h0000_0000, base address of slave 0.
- P_SIZE, 1024, bytes per slave region; power of two.
- P_TIMEOUT, 255, max ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_addr  in  32  byte address.
- req_write  in  1  1=write, 0=read.
- req_wdata  in  32  write data.
- req_strb  in  4  write byte strobes.
- req_prot  in  3  protection bits.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response taken when rsp_valid & rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR, decode error or timeout.
- PSEL  out  P_NUM  one-hot slave select.
- PADDR  out  32  address.
- PENABLE  out  1  access phase.
- PWRITE  out  1  direction.
- PWDATA  out  32  write data.
- PSTRB  out  4  strobes; forced 4'h0 on reads.
- PPROT  out  3  protection.
- PRDATA  in  32*P_NUM  concatenated read data; slave n at [32n+31:32n].
- PREADY  in  P_NUM  per-slave ready.
- PSLVERR  in  P_NUM  per-slave error.

Behaviour:
- Reset values (PRESET sampled high on an edge):
  - state=IDLE.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.
- Reset mid-transfer: the transfer is dropped with no response; PSEL/PENABLE are low from the next edge.
- req_ready=1 only in IDLE and not in reset; combinational from state.
- Decode: off = req_addr - P_ADDR_START (32-bit unsigned).
  - idx = off / P_SIZE; hit if req_addr >= P_ADDR_START and idx < P_NUM.
  - Decode is registered at acceptance.
- FSM states:
  - IDLE: on accept, latch request fields and idx.
    - Hit: next state SETUP.
    - Miss: next state RESP with rsp_err=1, rsp_rdata=0; no APB activity.
  - SETUP (one cycle): PSEL[idx]=1, PENABLE=0; PADDR/PWRITE/PWDATA/PSTRB/PPROT driven from latched values. Next state ACCESS.
  - ACCESS: PSEL[idx]=1, PENABLE=1; counter increments each cycle PREADY[idx]=0.
    - PREADY[idx]=1: capture rsp_err=PSLVERR[idx]; capture rsp_rdata=PRDATA slice for reads with no error, else 0. Next state RESP.
    - Timeout (counter reaches P_TIMEOUT with PREADY[idx] still 0, P_TIMEOUT>0): rsp_err=1, rsp_rdata=0. Next state RESP; PSEL/PENABLE drop.
  - RESP: PSEL=0, PENABLE=0, rsp_valid=1, rsp_rdata/rsp_err held stable. When rsp_ready=1, next state IDLE and rsp_valid=0.
- Address/control stability: PADDR, PWRITE, PWDATA, PSTRB and PPROT are stable from SETUP through the final ACCESS cycle. Outside transfers they hold their last value (no requirement to zero them).
- Latency: accept at edge N -> SETUP in cycle N+1 -> ACCESS in N+2; zero-wait rsp_valid in N+3. Each PREADY-low cycle adds one.
- Throughput: with rsp_ready tied high, one transfer per 4 cycles.
- Only slave idx's PREADY/PSLVERR/PRDATA are observed; other slaves' signals are ignored.
- PSEL never has more than one bit set; PENABLE never high without PSEL.

Test Plan:
- Write/read: write 32'hDEAD_BEEF to 32'h0000_0404 (slave 1, strb 4'hF), then read it -> PSEL=3'b010 on both; read rsp_rdata=32'hDEAD_BEEF, rsp_err=0; rsp_valid 3 cycles after accept.
- Wait states: slave 2 memory with DELAY=3, read 32'h0000_0810 -> ACCESS lasts 4 cycles; rsp_valid 6 cycles after accept; PADDR stable throughout.
- Decode error: read 32'h0000_0C00 (P_NUM=3, P_SIZE=1024) -> no PSEL asserted; rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
- Timeout and PSLVERR: P_TIMEOUT=4 with PREADY stuck low -> abort after 4 ACCESS cycles with rsp_err=1; forced PSLVERR=1 with PREADY=1 -> rsp_err=1, rsp_rdata=0.
- Backpressure and reset: hold rsp_ready=0 for 5 cycles -> rsp_valid stays high, data stable, req_ready=0. Assert PRESET during ACCESS -> PSEL=0, PENABLE=0, rsp_valid=0 at the next edge; new request accepted after reset releases.
